uart_rx: RTL and testbench

UART receiver: the receive end of the team's UART link, matched to the existing transmitter's frame format. Frame is start(0), DATA_WIDTH data bits LSB-first, optional parity, stop(1). The receiver oversamples rx_in at `prescale` clocks per bit and takes a 3-sample majority vote at mid-bit. It outputs the parallel word with a one-cycle valid pulse and flags parity/stop errors.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_rx_sampler.sv | 49 ++++
 rtl/uart_rx.sv | 146 ++++++++++++++
 tb/tb_uart_rx.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Types and constants shared by the UART receiver and transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit timing for the receiver: edge counter, three mid-bit samples and
// a majority vote on the synchronized line.
module uart_rx_sampler #(
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx_s_i,
    input  logic                      start_i,
    input  logic                      run_i,
    input  logic [PRESCALE_WIDTH-1:0] prescale_i,
    output logic                      bit_val_o,
    output logic                      bit_strobe_o,
    output logic                      bit_end_o
);

    localparam logic [PRESCALE_WIDTH-1:0] ONE = 1;

    logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;
    logic [PRESCALE_WIDTH-1:0] half;
    logic                      s0_q, s1_q;

    assign half         = prescale_i >> 1;
    assign bit_end_o    = run_i && (cnt_q == prescale_i - ONE);
    assign bit_strobe_o = run_i && (cnt_q == half + ONE);
    assign bit_val_o    = (s0_q & s1_q) | (s0_q & rx_s_i) | (s1_q & rx_s_i);

    // The start-detect cycle is edge 0 of the start bit, so the count resumes at 1.
    always_comb begin
        cnt_d = '0;
        if (start_i)
            cnt_d = ONE;
        else if (run_i)
            cnt_d = bit_end_o ? '0 : cnt_q + ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            s0_q  <= 1'b1;
            s1_q  <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            if (run_i && cnt_q == half - ONE) s0_q <= rx_s_i;
            if (run_i && cnt_q == half)       s1_q <= rx_s_i;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start/data/parity/stop framing, majority-voted bits,
// one-cycle valid / parity-error / stop-error reports.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6,
    parameter int BIT_CNT_WIDTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx_in,
    input  logic                      par_en,
    input  logic                      par_type,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic [DATA_WIDTH-1:0]     p_data,
    output logic                      data_valid,
    output logic                      par_err,
    output logic                      stop_err,
    output logic                      busy
);

    localparam logic [BIT_CNT_WIDTH-1:0] LAST_BIT = BIT_CNT_WIDTH'(DATA_WIDTH - 1);

    rx_state_e                 state_q, state_d;
    logic                      rx_meta_q, rx_s_q;
    logic [PRESCALE_WIDTH-1:0] pre_q;
    logic                      par_en_q, par_type_q;
    logic [DATA_WIDTH-1:0]     shreg_q, shreg_d;
    logic [BIT_CNT_WIDTH-1:0]  bit_cnt_q, bit_cnt_d;
    logic                      par_bad_q, par_bad_d;
    logic                      wait_high_q, wait_high_d;
    logic [DATA_WIDTH-1:0]     p_data_q, p_data_d;
    logic                      dv_q, dv_d, pe_q, pe_d, se_q, se_d;
    logic                      start_det, bit_val, bit_strobe, bit_end;

    assign start_det = (state_q == IDLE) && !wait_high_q && !rx_s_q;

    uart_rx_sampler #(.PRESCALE_WIDTH(PRESCALE_WIDTH)) u_sampler (
        .clk          (clk),
        .rst          (rst),
        .rx_s_i       (rx_s_q),
        .start_i      (start_det),
        .run_i        (state_q != IDLE),
        .prescale_i   (pre_q),
        .bit_val_o    (bit_val),
        .bit_strobe_o (bit_strobe),
        .bit_end_o    (bit_end)
    );

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        par_bad_d   = par_bad_q;
        wait_high_d = wait_high_q;
        p_data_d    = p_data_q;
        dv_d        = 1'b0;
        pe_d        = 1'b0;
        se_d        = 1'b0;
        case (state_q)
            IDLE: begin
                par_bad_d = 1'b0;
                bit_cnt_d = '0;
                // After a break the line must go high before a new start counts.
                if (wait_high_q) begin
                    if (rx_s_q) wait_high_d = 1'b0;
                end else if (!rx_s_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (bit_strobe && bit_val) state_d = IDLE;
                else if (bit_end)          state_d = DATA;
            end
            DATA: begin
                if (bit_strobe) shreg_d = {bit_val, shreg_q[DATA_WIDTH-1:1]};
                if (bit_end) begin
                    if (bit_cnt_q == LAST_BIT) state_d = par_en_q ? PARITY : STOP;
                    else                       bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            PARITY: begin
                if (bit_strobe) par_bad_d = bit_val ^ (^shreg_q) ^ par_type_q;
                if (bit_end)    state_d = STOP;
            end
            STOP: begin
                // Leave on the decision edge, not the bit end, to tolerate a slow sender.
                if (bit_strobe) begin
                    state_d     = IDLE;
                    wait_high_d = !bit_val;
                    if (par_bad_q)     pe_d = 1'b1;
                    else if (!bit_val) se_d = 1'b1;
                    else begin
                        dv_d     = 1'b1;
                        p_data_d = shreg_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            pre_q       <= '0;
            par_en_q    <= 1'b0;
            par_type_q  <= 1'b0;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            par_bad_q   <= 1'b0;
            wait_high_q <= 1'b0;
            p_data_q    <= '0;
            dv_q        <= 1'b0;
            pe_q        <= 1'b0;
            se_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_meta_q   <= rx_in;
            rx_s_q      <= rx_meta_q;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            par_bad_q   <= par_bad_d;
            wait_high_q <= wait_high_d;
            p_data_q    <= p_data_d;
            dv_q        <= dv_d;
            pe_q        <= pe_d;
            se_q        <= se_d;
            if (state_q == IDLE) begin
                pre_q      <= prescale;
                par_en_q   <= par_en;
                par_type_q <= par_type;
            end
        end
    end

    assign p_data     = p_data_q;
    assign data_valid = dv_q;
    assign par_err    = pe_q;
    assign stop_err   = se_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames plus randomized frames scored against
// a frame-level model of the expected report.
module tb_uart_rx;

    localparam int W  = 8;
    localparam int PW = 6;

    logic          clk = 1'b0;
    logic          rst, rx_in, par_en, par_type;
    logic [PW-1:0] prescale;
    logic [W-1:0]  p_data;
    logic          data_valid, par_err, stop_err, busy;

    int           n_tests = 0, n_fail = 0;
    int           npe, nse, nbusy;
    logic [W-1:0] vq[$];
    logic [W-1:0] exp_pdata;

    always #5 clk = ~clk;

    uart_rx dut (
        .clk(clk), .rst(rst), .rx_in(rx_in), .par_en(par_en), .par_type(par_type),
        .prescale(prescale), .p_data(p_data), .data_valid(data_valid),
        .par_err(par_err), .stop_err(stop_err), .busy(busy)
    );

    always @(negedge clk) begin
        if (data_valid === 1'b1) vq.push_back(p_data);
        npe   += int'(par_err);
        nse   += int'(stop_err);
        nbusy += int'(busy);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear();
        vq.delete();
        npe = 0; nse = 0; nbusy = 0;
    endtask

    // Drives one frame at exactly pre clocks per bit; optional one-clock glitch
    // mid data bit gbit; optional config scrambling while the frame is in flight.
    task automatic send(input logic [W-1:0] d, input bit pe, input bit pbit, input bit sbit,
                        input int pre, input bit scr, input int gbit);
        logic [PW-1:0] sv_pre;
        bit sv_en, sv_ty;
        sv_pre = prescale; sv_en = par_en; sv_ty = par_type;
        rx_in = 1'b0; tick(pre);
        for (int i = 0; i < W; i++) begin
            rx_in = d[i];
            if (scr && i == 0) begin
                prescale = PW'($urandom_range(4, 63));
                par_en = ~par_en; par_type = ~par_type;
            end
            if (i == gbit) begin
                tick(pre / 2); rx_in = ~d[i]; tick(1); rx_in = d[i]; tick(pre - pre / 2 - 1);
            end else tick(pre);
        end
        if (pe) begin rx_in = pbit; tick(pre); end
        prescale = sv_pre; par_en = sv_en; par_type = sv_ty;
        rx_in = sbit; tick(pre);
        rx_in = 1'b1;
    endtask

    task automatic check_report(input string tag, input int ev, input int epe, input int ese);
        chk({tag, "_nvalid"}, vq.size(), ev);
        if (ev == 1 && vq.size() > 0) chk({tag, "_word"}, vq[0], exp_pdata);
        chk({tag, "_par_err"}, npe, epe);
        chk({tag, "_stop_err"}, nse, ese);
        chk({tag, "_p_data"}, p_data, exp_pdata);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic run_frame(input string tag, input logic [W-1:0] d, input bit pe, input bit pt,
                             input bit flip, input bit sbit, input int pre, input bit scr,
                             input int gbit);
        bit pbit;
        prescale = PW'(pre); par_en = pe; par_type = pt;
        tick(2);
        pbit = (^d) ^ pt ^ flip;
        clear();
        send(d, pe, pbit, sbit, pre, scr, gbit);
        tick(2 * pre + 4);
        if (pe && flip)  check_report(tag, 0, 1, 0);
        else if (!sbit)  check_report(tag, 0, 0, 1);
        else begin
            exp_pdata = d;
            check_report(tag, 1, 0, 0);
        end
    endtask

    initial begin
        rst = 1'b1; rx_in = 1'b1; par_en = 1'b0; par_type = 1'b0; prescale = PW'(8);
        exp_pdata = '0;
        tick(3);
        chk("rst_p_data", p_data, 0);
        chk("rst_outs", {data_valid, par_err, stop_err, busy}, 0);
        rst = 1'b0;
        tick(4);

        run_frame("t1", 8'hA5, 0, 0, 0, 1, 8, 0, -1);
        chk("t1_busy_len", (nbusy >= 9 * 8 && nbusy <= 10 * 8), 1);

        run_frame("t2_even", 8'h3C, 1, 0, 0, 1, 16, 0, -1);
        run_frame("t2_odd", 8'h3C, 1, 1, 0, 1, 16, 0, -1);
        run_frame("t3_parbad", 8'h01, 1, 0, 1, 1, 8, 0, -1);

        // break: stop bit 0, line held low for 20 bits
        prescale = PW'(8); par_en = 1'b0; tick(2);
        clear();
        send(8'h55, 0, 0, 0, 8, 0, -1);
        rx_in = 1'b0;
        tick(20 * 8);
        check_report("t4_break", 0, 0, 1);
        rx_in = 1'b1; tick(16);
        run_frame("t4_after", 8'h12, 0, 0, 0, 1, 8, 0, -1);

        // short start pulse
        clear();
        rx_in = 1'b0; tick(2); rx_in = 1'b1; tick(40);
        check_report("t5_short", 0, 0, 0);
        run_frame("t5_glitch", 8'h00, 0, 0, 0, 1, 8, 0, 3);

        // back-to-back frames, no idle gap
        prescale = PW'(8); par_en = 1'b0; tick(2);
        clear();
        send(8'hFF, 0, 0, 1, 8, 0, -1);
        send(8'h00, 0, 0, 1, 8, 0, -1);
        tick(20);
        chk("t6_count", vq.size(), 2);
        if (vq.size() == 2) begin
            chk("t6_first", vq[0], 8'hFF);
            chk("t6_second", vq[1], 8'h00);
        end
        exp_pdata = 8'h00;

        // reset mid-frame
        clear();
        rx_in = 1'b0; tick(8); rx_in = 1'b1; tick(20);
        rst = 1'b1; tick(1);
        chk("t6_rst_p_data", p_data, 0);
        chk("t6_rst_outs", {data_valid, par_err, stop_err, busy}, 0);
        rst = 1'b0; exp_pdata = '0;
        tick(100);
        check_report("t6_post_rst", 0, 0, 0);
        run_frame("t6_81", 8'h81, 0, 0, 0, 1, 8, 0, -1);

        for (int k = 0; k < 40; k++) begin
            run_frame("rnd", W'($urandom), bit'($urandom), bit'($urandom),
                      ($urandom % 5) == 0, ($urandom % 5) != 0, $urandom_range(4, 20),
                      bit'($urandom), (($urandom % 3) == 0) ? int'($urandom % W) : -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
